// File: rtl/spi_slave.sv
// -----------------------------------------------------------------------------
// spi_slave
//
// Purpose:
//   SPI target front end. It oversamples SCK/CS/MOSI on GCLK and shifts a
//   left-aligned word in from MOSI while shifting tx_data out on MISO.
//   Each received word is presented with a one-cycle rx_valid pulse.
//   One CS frame may carry several back-to-back words. tx_data is re-captured
//   at every word boundary, and word_len is re-latched there as well.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on i_SCK, i_CS and i_MOSI (>= 2)
//
// Ports:
//   GCLK       in   system clock
//   RST        in   asynchronous active-low reset
//   spi_mode   in   [1]=CPOL, [0]=CPHA; latched at frame start
//   word_len   in   00=8, 01=16, 10=24, 11=32 bits; latched at frame start
//                   and at each word boundary
//   tx_data    in   next word to transmit, bit 31 goes out first
//   tx_taken   out  pulse: tx_data was captured into the shifter
//   rx_data    out  last received word, MSB-aligned, unused low bits zero
//   rx_valid   out  pulse: rx_data updated
//   busy       out  high while a frame is in progress
//   frame_err  out  pulse: CS released with a partial word
//   i_SCK, i_CS, i_MOSI  in   SPI bus inputs (CS active-low)
//   o_MISO     out  SPI data to the master
//
// Build option:
//   SPI_SLAVE_MISO_TRISTATE_EN  when defined, o_MISO floats (1'bz) in IDLE so
//                               several targets can share MISO; otherwise it
//                               is driven 0 in IDLE.
// -----------------------------------------------------------------------------
module spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        GCLK,
   input  logic        RST,
   input  logic [1:0]  spi_mode,
   input  logic [1:0]  word_len,
   input  logic [31:0] tx_data,
   output logic        tx_taken,
   output logic [31:0] rx_data,
   output logic        rx_valid,
   output logic        busy,
   output logic        frame_err,
   input  logic        i_SCK,
   input  logic        i_CS,
   input  logic        i_MOSI,
   output logic        o_MISO
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronizers and edge-detect history
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sck_sync_reg;
   logic [SYNC_STAGES-1:0] cs_sync_reg;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic                   sck_prev_reg;
   logic                   cs_prev_reg;

   // CS history resets to 0 (asserted) on purpose. If CS is already low when
   // reset is released, no falling edge is seen. The block then waits for
   // CS to go high and fall again. If CS is high, the synchronizer ripples up
   // to 1, and that rise is ignored in IDLE.
   always_ff @(posedge GCLK or negedge RST) begin
      if (!RST) begin
         sck_sync_reg  <= '0;
         cs_sync_reg   <= '0;
         mosi_sync_reg <= '0;
         sck_prev_reg  <= 1'b0;
         cs_prev_reg   <= 1'b0;
      end else begin
         sck_sync_reg  <= {sck_sync_reg[SYNC_STAGES-2:0], i_SCK};
         cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], i_CS};
         mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], i_MOSI};
         sck_prev_reg  <= sck_sync_reg[SYNC_STAGES-1];
         cs_prev_reg   <= cs_sync_reg[SYNC_STAGES-1];
      end
   end

   logic sck_s;
   logic cs_s;
   logic mosi_s;
   assign sck_s  = sck_sync_reg[SYNC_STAGES-1];
   assign cs_s   = cs_sync_reg[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

   logic cs_fall;
   logic cs_rise;
   assign cs_fall =  cs_prev_reg & ~cs_s;
   assign cs_rise = ~cs_prev_reg &  cs_s;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_t      state_reg,     state_next;
   logic [1:0]  mode_reg,      mode_next;
   logic [1:0]  len_reg,       len_next;
   logic [31:0] tx_shift_reg,  tx_shift_next;
   logic [31:0] rx_shift_reg,  rx_shift_next;
   logic [4:0]  bit_cnt_reg,   bit_cnt_next;
   logic        hold_reg,      hold_next;
   logic [31:0] rx_data_reg,   rx_data_next;
   logic        rx_valid_reg,  rx_valid_next;
   logic        tx_taken_reg,  tx_taken_next;
   logic        busy_reg,      busy_next;
   logic        frame_err_reg, frame_err_next;

   always_ff @(posedge GCLK or negedge RST) begin
      if (!RST) begin
         state_reg     <= IDLE;
         mode_reg      <= 2'b00;
         len_reg       <= 2'b00;
         tx_shift_reg  <= '0;
         rx_shift_reg  <= '0;
         bit_cnt_reg   <= '0;
         hold_reg      <= 1'b0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         tx_taken_reg  <= 1'b0;
         busy_reg      <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         len_reg       <= len_next;
         tx_shift_reg  <= tx_shift_next;
         rx_shift_reg  <= rx_shift_next;
         bit_cnt_reg   <= bit_cnt_next;
         hold_reg      <= hold_next;
         rx_data_reg   <= rx_data_next;
         rx_valid_reg  <= rx_valid_next;
         tx_taken_reg  <= tx_taken_next;
         busy_reg      <= busy_next;
         frame_err_reg <= frame_err_next;
      end
   end

   // ------------------------------------------------------------------
   // Next-state / datapath logic
   // ------------------------------------------------------------------
   logic        cpol;
   logic        cpha;
   logic        lead_edge;
   logic        trail_edge;
   logic        sample_edge;
   logic        shift_edge;
   logic        word_done;
   logic [31:0] rx_word;
   logic [4:0]  rx_shamt;

   assign cpol = mode_reg[1];
   assign cpha = mode_reg[0];

   // Leading edge: SCK leaves its idle level (CPOL). Trailing edge: it returns.
   assign lead_edge  = (sck_prev_reg == cpol) && (sck_s != cpol);
   assign trail_edge = (sck_prev_reg != cpol) && (sck_s == cpol);

   // The last bit index of an N-bit word is N-1, which equals {len,3'b111}.
   // Left-justifying needs a shift of 32-N, which equals {~len,3'b000}.
   assign rx_shamt = {~len_reg, 3'b000};

   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      len_next       = len_reg;
      tx_shift_next  = tx_shift_reg;
      rx_shift_next  = rx_shift_reg;
      bit_cnt_next   = bit_cnt_reg;
      hold_next      = hold_reg;
      rx_data_next   = rx_data_reg;
      rx_valid_next  = 1'b0;
      tx_taken_next  = 1'b0;
      busy_next      = busy_reg;
      frame_err_next = 1'b0;
      sample_edge    = 1'b0;
      shift_edge     = 1'b0;
      word_done      = 1'b0;
      rx_word        = '0;

      case (state_reg)
         IDLE: begin
            if (cs_fall) begin
               state_next    = SHIFT;
               mode_next     = spi_mode;
               len_next      = word_len;
               tx_shift_next = tx_data;
               tx_taken_next = 1'b1;
               bit_cnt_next  = '0;
               busy_next     = 1'b1;
               // With CPHA=1 the first leading edge only presents bit 31.
               hold_next     = spi_mode[0];
            end
         end

         SHIFT: begin
            sample_edge = cpha ? trail_edge : lead_edge;
            shift_edge  = cpha ? lead_edge  : trail_edge;

            // The first shift edge after a load is swallowed when hold is set.
            // For CPHA=1 that is the first leading edge of the word. For
            // CPHA=0 it is the trailing edge right after a word boundary, so
            // the freshly loaded bit 31 is not lost.
            if (shift_edge) begin
               if (hold_reg) begin
                  hold_next = 1'b0;
               end else begin
                  tx_shift_next = {tx_shift_reg[30:0], 1'b0};
               end
            end

            if (sample_edge) begin
               rx_word       = {rx_shift_reg[30:0], mosi_s};
               rx_shift_next = rx_word;
               if (bit_cnt_reg == {len_reg, 3'b111}) begin
                  word_done     = 1'b1;
                  rx_data_next  = rx_word << rx_shamt;
                  rx_valid_next = 1'b1;
                  bit_cnt_next  = '0;
                  // If CS is released on this very cycle, nothing more is
                  // sent, so tx_data is not consumed.
                  if (!cs_rise) begin
                     tx_shift_next = tx_data;
                     tx_taken_next = 1'b1;
                     len_next      = word_len;
                     hold_next     = 1'b1;
                  end
               end else begin
                  bit_cnt_next = bit_cnt_reg + 5'd1;
               end
            end

            if (cs_rise) begin
               state_next   = IDLE;
               busy_next    = 1'b0;
               bit_cnt_next = '0;
               if (!word_done && ((bit_cnt_reg != 5'd0) || sample_edge)) begin
                  frame_err_next = 1'b1;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign tx_taken  = tx_taken_reg;
   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign busy      = busy_reg;
   assign frame_err = frame_err_reg;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   assign o_MISO = (state_reg == SHIFT) ? tx_shift_reg[31] : 1'bz;
`else
   assign o_MISO = (state_reg == SHIFT) ? tx_shift_reg[31] : 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_slave
//
// Self-checking bench for spi_slave. A behavioural SPI master drives frames
// bit by bit. Expected received words and expected MISO words come from the
// transmitted words masked to the word length. Pulse counts come from the
// frame shape.
// -----------------------------------------------------------------------------
module tb_spi_slave;

   logic        GCLK;
   logic        RST;
   logic [1:0]  spi_mode;
   logic [1:0]  word_len;
   logic [31:0] tx_data;
   logic        tx_taken;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;
   logic        frame_err;
   logic        i_SCK;
   logic        i_CS;
   logic        i_MOSI;
   logic        o_MISO;

   spi_slave #(.SYNC_STAGES(2)) dut (
      .GCLK      (GCLK),
      .RST       (RST),
      .spi_mode  (spi_mode),
      .word_len  (word_len),
      .tx_data   (tx_data),
      .tx_taken  (tx_taken),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .frame_err (frame_err),
      .i_SCK     (i_SCK),
      .i_CS      (i_CS),
      .i_MOSI    (i_MOSI),
      .o_MISO    (o_MISO)
   );

   initial begin
      GCLK = 1'b0;
      forever #5 GCLK = ~GCLK;
   end

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
   localparam logic MISO_IDLE = 1'bz;
`else
   localparam logic MISO_IDLE = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Pulse monitor, sampled on the falling edge away from DUT updates.
   logic [31:0] rx_q[$];
   int          tx_cnt;
   int          align_cnt;
   int          fe_cnt;

   initial begin
      tx_cnt    = 0;
      align_cnt = 0;
      fe_cnt    = 0;
   end

   always @(negedge GCLK) begin
      if (rx_valid === 1'b1) rx_q.push_back(rx_data);
      if (tx_taken === 1'b1) tx_cnt++;
      if (tx_taken === 1'b1 && rx_valid === 1'b1) align_cnt++;
      if (frame_err === 1'b1) fe_cnt++;
   end

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge GCLK);
   endtask

   task automatic clear_monitor();
      rx_q.delete();
      tx_cnt    = 0;
      align_cnt = 0;
      fe_cnt    = 0;
   endtask

   logic [31:0] tx_words[5];
   logic [31:0] mosi_words[4];
   logic [31:0] last_rx;

   // One master frame. abort_bits >= 0 releases CS after that many bits of
   // the first word. cs_on_last (CPHA=1 only) releases CS together with the
   // final trailing edge.
   task automatic run_frame(input logic [1:0] mode, input logic [1:0] len,
                            input int nwords, input int half,
                            input int abort_bits, input bit cs_on_last);
      int          n;
      logic        cpol;
      logic        cpha;
      logic [31:0] mask;
      logic [31:0] miso_word;
      bit          aborted;
      int          exp_rx_cnt;
      int          exp_tx_cnt;
      int          exp_align;
      n       = 8 * (int'(len) + 1);
      cpol    = mode[1];
      cpha    = mode[0];
      mask    = 32'hFFFF_FFFF << (32 - n);
      aborted = 1'b0;
      $display("frame: mode=%0d len=%0d bits=%0d words=%0d half=%0d abort=%0d cs_on_last=%0d tx0=%h mosi0=%h",
               mode, len, n, nwords, half, abort_bits, cs_on_last, tx_words[0], mosi_words[0]);

      i_CS     = 1'b1;
      spi_mode = mode;
      word_len = len;
      tx_data  = tx_words[0];
      i_SCK    = cpol;
      i_MOSI   = 1'b0;
      wait_cycles(6);
      clear_monitor();
      i_CS = 1'b0;
      if (!cpha) i_MOSI = mosi_words[0][31];
      wait_cycles(half + 2);

      for (int k = 0; k < nwords; k++) begin
         miso_word = '0;
         for (int j = 0; j < n; j++) begin
            if (abort_bits >= 0 && j == abort_bits) begin
               aborted = 1'b1;
               break;
            end
            i_SCK = ~cpol;
            if (cpha) i_MOSI = mosi_words[k][31-j];
            else      miso_word[31-j] = o_MISO;
            if (j == 0) begin
               tx_data = tx_words[k+1];
               if (k == 0) check_eq("busy_in_frame", {31'b0, busy}, 32'd1);
            end
            wait_cycles(half);
            i_SCK = cpol;
            if (cpha) begin
               miso_word[31-j] = o_MISO;
            end else if (j + 1 < n) begin
               i_MOSI = mosi_words[k][30-j];
            end else if (k + 1 < nwords) begin
               i_MOSI = mosi_words[k+1][31];
            end
            if (cs_on_last && k == nwords - 1 && j == n - 1) i_CS = 1'b1;
            wait_cycles(half);
         end
         if (aborted) break;
         check_eq("miso_word", miso_word, tx_words[k] & mask);
      end

      i_CS = 1'b1;
      wait_cycles(6);

      exp_rx_cnt = aborted ? 0 : nwords;
      exp_tx_cnt = aborted ? 1 : (cs_on_last ? nwords : nwords + 1);
      exp_align  = aborted ? 0 : (cs_on_last ? nwords - 1 : nwords);
      check_eq("rx_valid_count", rx_q.size(), exp_rx_cnt);
      for (int k = 0; k < exp_rx_cnt; k++) begin
         if (k < rx_q.size()) check_eq("rx_word", rx_q[k], mosi_words[k] & mask);
      end
      if (!aborted) last_rx = mosi_words[nwords-1] & mask;
      check_eq("tx_taken_count", tx_cnt, exp_tx_cnt);
      check_eq("tx_rx_aligned", align_cnt, exp_align);
      check_eq("frame_err_count", fe_cnt, aborted ? 1 : 0);
      check_eq("rx_data_hold", rx_data, last_rx);
      check_eq("busy_after", {31'b0, busy}, 32'd0);
      check_eq("miso_idle", {31'b0, o_MISO}, {31'b0, MISO_IDLE});
   endtask

   initial begin
      RST      = 1'b0;
      spi_mode = 2'b00;
      word_len = 2'b00;
      tx_data  = '0;
      i_SCK    = 1'b0;
      i_CS     = 1'b1;
      i_MOSI   = 1'b0;
      last_rx  = '0;
      wait_cycles(3);
      check_eq("rst_rx_data",   rx_data, 32'd0);
      check_eq("rst_rx_valid",  {31'b0, rx_valid}, 32'd0);
      check_eq("rst_tx_taken",  {31'b0, tx_taken}, 32'd0);
      check_eq("rst_busy",      {31'b0, busy}, 32'd0);
      check_eq("rst_frame_err", {31'b0, frame_err}, 32'd0);
      check_eq("rst_miso",      {31'b0, o_MISO}, {31'b0, MISO_IDLE});
      RST = 1'b1;
      wait_cycles(6);

      // Mode 2, 24-bit word.
      tx_words[0]   = 32'h5A3C_0F00;
      tx_words[1]   = 32'h0;
      mosi_words[0] = 32'hAA00_0000;
      run_frame(2'd2, 2'd2, 1, 8, -1, 1'b0);

      // All four modes, 8-bit.
      for (int m = 0; m < 4; m++) begin
         tx_words[0]   = 32'hC300_0000;
         tx_words[1]   = $urandom;
         mosi_words[0] = 32'h8700_0000;
         run_frame(2'(m), 2'd0, 1, 8, -1, 1'b0);
      end

      // Two back-to-back 16-bit words in one CS.
      tx_words[0]   = $urandom;
      tx_words[1]   = $urandom;
      tx_words[2]   = $urandom;
      mosi_words[0] = 32'h8759_0000;
      mosi_words[1] = 32'h1234_0000;
      run_frame(2'd1, 2'd1, 2, 6, -1, 1'b0);

      // CS released after 5 bits of an 8-bit word.
      tx_words[0]   = $urandom;
      tx_words[1]   = $urandom;
      mosi_words[0] = $urandom;
      run_frame(2'd0, 2'd0, 1, 6, 5, 1'b0);

      // CS release on the same cycle as the final sample.
      tx_words[0]   = $urandom;
      tx_words[1]   = $urandom;
      mosi_words[0] = $urandom;
      run_frame(2'd3, 2'd0, 1, 6, -1, 1'b1);

      // Reset asserted at bit 10 of a 32-bit word, with CS still low afterwards.
      $display("reset-mid-frame: mode=0 len=3 bits_before_reset=10");
      spi_mode = 2'b00;
      word_len = 2'b11;
      tx_data  = $urandom;
      i_SCK    = 1'b0;
      i_CS     = 1'b1;
      wait_cycles(6);
      i_CS   = 1'b0;
      i_MOSI = 1'b1;
      wait_cycles(8);
      for (int j = 0; j < 10; j++) begin
         i_SCK = 1'b1;
         wait_cycles(6);
         i_SCK  = 1'b0;
         i_MOSI = 1'($urandom);
         wait_cycles(6);
      end
      RST = 1'b0;
      #1;
      check_eq("mid_rst_rx_data",  rx_data, 32'd0);
      check_eq("mid_rst_busy",     {31'b0, busy}, 32'd0);
      check_eq("mid_rst_rx_valid", {31'b0, rx_valid}, 32'd0);
      check_eq("mid_rst_tx_taken", {31'b0, tx_taken}, 32'd0);
      check_eq("mid_rst_miso",     {31'b0, o_MISO}, {31'b0, MISO_IDLE});
      last_rx = '0;
      wait_cycles(3);
      RST = 1'b1;
      clear_monitor();
      for (int j = 0; j < 4; j++) begin
         i_SCK = 1'b1;
         wait_cycles(6);
         i_SCK = 1'b0;
         wait_cycles(6);
      end
      check_eq("post_rst_busy",     {31'b0, busy}, 32'd0);
      check_eq("post_rst_rx_count", rx_q.size(), 32'd0);
      check_eq("post_rst_tx_count", tx_cnt, 32'd0);
      i_CS = 1'b1;
      wait_cycles(6);
      check_eq("post_rst_fe_count", fe_cnt, 32'd0);

      tx_words[0]   = $urandom;
      tx_words[1]   = $urandom;
      mosi_words[0] = 32'hDEAD_BEEF;
      run_frame(2'($urandom_range(0, 3)), 2'd3, 1, 6, -1, 1'b0);

      // Randomized frames.
      for (int r = 0; r < 16; r++) begin
         int nw;
         nw = int'($urandom_range(1, 3));
         for (int k = 0; k < 5; k++) tx_words[k] = $urandom;
         for (int k = 0; k < 4; k++) mosi_words[k] = $urandom;
         run_frame(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), nw,
                   int'($urandom_range(4, 8)), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
